// File: rtl/eq_codec_pkg.sv
// -----------------------------------------------------------------------------
// eq_codec_pkg
//   Shared constants and types for the CS4272 serial audio port.
//   The frame is 1024 system clocks long and is addressed by a 10-bit counter.
//   The left half-frame is cnt 0x000-0x1FF and the right half-frame is
//   0x200-0x3FF. Each half carries 16 SCLK periods of 32 clks each.
//   Every named event below is a counter value or a value of the counter's
//   low five bits.
// -----------------------------------------------------------------------------
package eq_codec_pkg;

   localparam int unsigned CNT_W = 10;

   // Low five bits of cnt: the first clk with SCLK high, where SDout is sampled
   localparam logic [4:0] RX_SMPL = 5'h10;
   // Low five bits of cnt: the last clk of an SCLK period, where SDin advances
   localparam logic [4:0] TX_SHFT = 5'h1F;

   // Left word fully received (bit 0 sampled)
   localparam logic [CNT_W-1:0] LFT_DONE = 10'h1F0;
   // Right word fully received
   localparam logic [CNT_W-1:0] RHT_DONE = 10'h3F0;
   // Last clk of the left half: the right word is loaded into the tx shifter
   localparam logic [CNT_W-1:0] RHT_LOAD = 10'h1FF;
   // Last clk of the frame: tx capture, left-word load, and the RSTn release point
   localparam logic [CNT_W-1:0] FRM_END = 10'h3FF;

   typedef logic signed [15:0] aud_smpl_t;

endpackage : eq_codec_pkg

// File: rtl/codec_clk_gen.sv
// -----------------------------------------------------------------------------
// codec_clk_gen
//   Free-running 10-bit frame counter and the codec clock and reset pins.
//   All outputs come straight from flops. The clock flops are loaded from the
//   next counter value, so MCLK == cnt[1], SCLK == cnt[4] and LRCLK == cnt[9]
//   hold on every clk, with no one-cycle skew.
// Ports
//   clk     in   system clock (50 MHz)
//   rst_n   in   asynchronous active-low reset
//   cnt_o   out  current frame counter value
//   mclk_o  out  codec master clock, clk/4
//   sclk_o  out  serial bit clock, clk/32
//   lrclk_o out  frame clock, clk/1024 (low = left half)
//   rstn_o  out  codec reset pin; goes high after the first full frame of clocks
// -----------------------------------------------------------------------------
module codec_clk_gen
   import eq_codec_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   output logic [CNT_W-1:0] cnt_o,
   output logic             mclk_o,
   output logic             sclk_o,
   output logic             lrclk_o,
   output logic             rstn_o
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic             mclk_q;
   logic             mclk_d;
   logic             sclk_q;
   logic             sclk_d;
   logic             lrclk_q;
   logic             lrclk_d;
   logic             rstn_q;
   logic             rstn_d;

   // Next counter value, clock levels derived from it, and the sticky codec reset release
   always_comb begin
      cnt_d   = cnt_q + 10'd1;
      mclk_d  = cnt_d[1];
      sclk_d  = cnt_d[4];
      lrclk_d = cnt_d[9];
      // The codec has seen a full 1024-clk frame of running clocks once cnt
      // leaves 0x3FF. RSTn then stays released until rst_n.
      if (cnt_q == FRM_END) begin
         rstn_d = 1'b1;
      end else begin
         rstn_d = rstn_q;
      end
   end

   // Counter and clock/reset pin flops
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q   <= 10'd0;
         mclk_q  <= 1'b0;
         sclk_q  <= 1'b0;
         lrclk_q <= 1'b0;
         rstn_q  <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         mclk_q  <= mclk_d;
         sclk_q  <= sclk_d;
         lrclk_q <= lrclk_d;
         rstn_q  <= rstn_d;
      end
   end

   assign cnt_o   = cnt_q;
   assign mclk_o  = mclk_q;
   assign sclk_o  = sclk_q;
   assign lrclk_o = lrclk_q;
   assign rstn_o  = rstn_q;

endmodule : codec_clk_gen

// File: rtl/codec_intf.sv
// -----------------------------------------------------------------------------
// codec_intf
//   Serial audio port between the CS4272 codec and the equalizer filter bank.
//   It derives MCLK, SCLK and LRCLK from the 50 MHz clock. It deserializes
//   SDout into L/R pairs and serializes L/R pairs onto SDin. Data is
//   left-justified and MSB first, with 16 bits per half-frame.
//   Build option: when CODEC_LOOPBACK_EN is defined, the transmit path captures
//   the last received pair (lft_in/rht_in) instead of lft_out/rht_out. The
//   port list is the same in both builds.
// Ports
//   clk      in   system clock, 50 MHz
//   rst_n    in   asynchronous active-low reset
//   lft_out  in   left sample to transmit (captured at cnt 0x3FF)
//   rht_out  in   right sample to transmit (captured at cnt 0x3FF)
//   SDout    in   serial data from the codec ADC
//   MCLK     out  clk/4
//   SCLK     out  clk/32
//   LRCLK    out  clk/1024, low = left, high = right
//   SDin     out  serial data to the codec DAC
//   RSTn     out  codec reset, active low
//   lft_in   out  last received left sample
//   rht_in   out  last received right sample
//   vld      out  one-clk pulse marking a new lft_in/rht_in pair
// -----------------------------------------------------------------------------
module codec_intf
   import eq_codec_pkg::*;
#(
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] lft_out,
   input  logic [DATA_W-1:0] rht_out,
   input  logic              SDout,
   output logic              MCLK,
   output logic              SCLK,
   output logic              LRCLK,
   output logic              SDin,
   output logic              RSTn,
   output logic [DATA_W-1:0] lft_in,
   output logic [DATA_W-1:0] rht_in,
   output logic              vld
);

   logic [CNT_W-1:0]  cnt_s;
   logic              rstn_s;

   // Receive path
   logic [DATA_W-1:0] rx_sr_q;
   logic [DATA_W-1:0] rx_sr_d;
   logic [DATA_W-1:0] rx_word_s;
   logic [DATA_W-1:0] rx_lft_sh_q;
   logic [DATA_W-1:0] rx_lft_sh_d;
   logic [DATA_W-1:0] lft_in_q;
   logic [DATA_W-1:0] lft_in_d;
   logic [DATA_W-1:0] rht_in_q;
   logic [DATA_W-1:0] rht_in_d;
   logic              vld_q;
   logic              vld_d;
   logic              armed_q;
   logic              armed_d;

   // Transmit path
   logic [DATA_W-1:0] tx_src_l_s;
   logic [DATA_W-1:0] tx_src_r_s;
   logic [DATA_W-1:0] tx_rht_sh_q;
   logic [DATA_W-1:0] tx_rht_sh_d;
   logic [DATA_W-1:0] tx_sr_q;
   logic [DATA_W-1:0] tx_sr_d;
   logic              tx_bit_s;
   logic              sdin_en_s;
   logic              sdin_q;
   logic              sdin_d;

   codec_clk_gen u_clk_gen (
      .clk     (clk),
      .rst_n   (rst_n),
      .cnt_o   (cnt_s),
      .mclk_o  (MCLK),
      .sclk_o  (SCLK),
      .lrclk_o (LRCLK),
      .rstn_o  (rstn_s)
   );

   // The word as it will stand once the bit sampled on this clk is shifted in.
   // At LFT_DONE and RHT_DONE it is a complete sample.
   assign rx_word_s = {rx_sr_q[DATA_W-2:0], SDout};

   // Deserializer, left shadow, output pair update and the one-frame vld arming
   always_comb begin
      rx_sr_d     = rx_sr_q;
      rx_lft_sh_d = rx_lft_sh_q;
      lft_in_d    = lft_in_q;
      rht_in_d    = rht_in_q;
      vld_d       = 1'b0;
      armed_d     = armed_q;

      if (cnt_s[4:0] == RX_SMPL) begin
         rx_sr_d = rx_word_s;
      end else begin
         rx_sr_d = rx_sr_q;
      end

      if (cnt_s == LFT_DONE) begin
         rx_lft_sh_d = rx_word_s;
      end else begin
         rx_lft_sh_d = rx_lft_sh_q;
      end

      // The first frame that ends with RSTn high only arms the output. The
      // codec's first frame after reset release is not trusted.
      if ((cnt_s == RHT_DONE) && rstn_s) begin
         armed_d = 1'b1;
         if (armed_q) begin
            lft_in_d = rx_lft_sh_q;
            rht_in_d = rx_word_s;
            vld_d    = 1'b1;
         end else begin
            vld_d    = 1'b0;
         end
      end else begin
         armed_d = armed_q;
      end
   end

   // Receive-side flops
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_sr_q     <= '0;
         rx_lft_sh_q <= '0;
         lft_in_q    <= '0;
         rht_in_q    <= '0;
         vld_q       <= 1'b0;
         armed_q     <= 1'b0;
      end else begin
         rx_sr_q     <= rx_sr_d;
         rx_lft_sh_q <= rx_lft_sh_d;
         lft_in_q    <= lft_in_d;
         rht_in_q    <= rht_in_d;
         vld_q       <= vld_d;
         armed_q     <= armed_d;
      end
   end

`ifdef CODEC_LOOPBACK_EN
   // ADC->DAC loopback: retransmit the most recently received pair
   assign tx_src_l_s = lft_in_q;
   assign tx_src_r_s = rht_in_q;
`else
   assign tx_src_l_s = lft_out;
   assign tx_src_r_s = rht_out;
`endif

   // SDin follows RSTn as seen on the same clk, so cnt 0x3FF already counts as released
   assign sdin_en_s = rstn_s | (cnt_s == FRM_END);

   // Serializer: coherent pair capture at frame end, right-word load at mid-frame, MSB-first shifting
   always_comb begin
      tx_rht_sh_d = tx_rht_sh_q;
      tx_sr_d     = tx_sr_q;
      tx_bit_s    = sdin_q;

      if (cnt_s == FRM_END) begin
         // The left word goes straight into the shifter, so its MSB is on SDin from cnt 0x000
         tx_rht_sh_d = tx_src_r_s;
         tx_sr_d     = {tx_src_l_s[DATA_W-2:0], 1'b0};
         tx_bit_s    = tx_src_l_s[DATA_W-1];
      end else if (cnt_s == RHT_LOAD) begin
         tx_sr_d     = {tx_rht_sh_q[DATA_W-2:0], 1'b0};
         tx_bit_s    = tx_rht_sh_q[DATA_W-1];
      end else if (cnt_s[4:0] == TX_SHFT) begin
         tx_sr_d     = {tx_sr_q[DATA_W-2:0], 1'b0};
         tx_bit_s    = tx_sr_q[DATA_W-1];
      end else begin
         tx_bit_s    = sdin_q;
      end

      if (sdin_en_s) begin
         sdin_d = tx_bit_s;
      end else begin
         sdin_d = 1'b0;
      end
   end

   // Transmit-side flops
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_rht_sh_q <= '0;
         tx_sr_q     <= '0;
         sdin_q      <= 1'b0;
      end else begin
         tx_rht_sh_q <= tx_rht_sh_d;
         tx_sr_q     <= tx_sr_d;
         sdin_q      <= sdin_d;
      end
   end

   assign SDin   = sdin_q;
   assign RSTn   = rstn_s;
   assign lft_in = lft_in_q;
   assign rht_in = rht_in_q;
   assign vld    = vld_q;

endmodule : codec_intf
